// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
//
// Ports:
//   i_sys_clk     system clock, all logic on the rising edge
//   i_sys_rst     synchronous reset, active-high
//   i_send_en     write strobe, one byte per asserted cycle
//   i_send_data   byte to send, taken when i_send_en && o_send_ready
//   o_send_ready  FIFO not full
//   o_fifo_cnt    bytes currently held in the FIFO
//   o_busy        frame on the line or FIFO non-empty
//   o_tx_pin      registered serial output, idle high
module uart_tx_fifo #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst,
  input  logic                          i_send_en,
  input  logic [7:0]                    i_send_data,
  output logic                          o_send_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_busy,
  output logic                          o_tx_pin
);

  localparam int RATE_CNT = CLK_FRE * 1000000 / UART_RATE - 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(RATE_CNT + 1);

  localparam logic [CW-1:0] RATE_END   = CW'(RATE_CNT);
  localparam logic [AW:0]   DEPTH_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // FIFO storage and pointers; one extra pointer bit distinguishes full from empty
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  // Serialiser state
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign fifo_cnt     = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (fifo_cnt == '0);
  assign o_send_ready = (fifo_cnt < DEPTH_FULL);
  assign push         = i_send_en && o_send_ready;
  assign fifo_head    = mem_q[rd_ptr_q[AW-1:0]];
  assign bit_end      = (cyc_q == RATE_END);

  assign o_fifo_cnt = fifo_cnt;
  assign o_busy     = (state_q != TX_IDLE) || !fifo_empty;
  assign o_tx_pin   = tx_q;

  assign wr_ptr_d = wr_ptr_q + (push ? (AW + 1)'(1) : '0);
  assign rd_ptr_d = rd_ptr_q + (pop  ? (AW + 1)'(1) : '0);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          cyc_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = TX_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            // shift register keeps the bit on the line in position 0
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          // chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            tx_d    = 1'b0;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (push && !i_sys_rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_send_data;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= TX_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 10 cycles per bit, FIFO depth 16.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic [4:0] cnt;
  logic       busy;
  logic       tx_pin;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  uart_tx_fifo #(
    .CLK_FRE   (1),
    .UART_RATE (100000),
    .FIFO_DEPTH(16)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_send_en   (en),
    .i_send_data (data),
    .o_send_ready(ready),
    .o_fifo_cnt  (cnt),
    .o_busy      (busy),
    .o_tx_pin    (tx_pin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Line receiver: samples the centre of each bit, aborts a frame on reset.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_bad = 0;

  initial begin
    logic [7:0] b;
    int         t0;
    bit         aborted;
    bit         ok;
    forever begin
      @(negedge clk);
      if (!rst && tx_pin === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        ok = 1'b1;
        b = '0;
        for (int k = 1; k <= 95; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (k == 5 && tx_pin !== 1'b0) ok = 1'b0;
          if (k >= 15 && k <= 85 && ((k - 15) % 10) == 0) b[(k - 15) / 10] = tx_pin;
          if (k == 95 && tx_pin !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
          if (!ok) rx_bad++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (5) tick();
  endtask

  task automatic clear_rx;
    rx_q.delete();
    rx_t.delete();
    rx_bad = 0;
  endtask

  task automatic check_frames(input string name, input int first, input int n, input int step);
    int bad_data = 0;
    int bad_pitch = 0;
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < rx_q.size() && i < n; i++) begin
      if (rx_q[i] !== 8'((first + i * step) & 8'hFF)) bad_data++;
      if (i > 0 && (rx_t[i] - rx_t[i-1]) != 100) bad_pitch++;
    end
    check({name, "_data_errors"}, bad_data, 0);
    check({name, "_pitch_errors"}, bad_pitch, 0);
    check({name, "_framing_errors"}, rx_bad, 0);
  endtask

  function automatic logic exp_level(input logic [7:0] b, input int t);
    int s = t / 10;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic       ready;
    logic [4:0] cnt;
    logic       busy;
    logic       tx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int low;
    int errs;
    logic r16, r17;

    vecs[0] = '{rst: 1'b1, en: 1'b0, data: 8'h00, ready: 1'b1, cnt: 5'd0, busy: 1'b0, tx: 1'b1};
    vecs[1] = '{rst: 1'b1, en: 1'b1, data: 8'h33, ready: 1'b1, cnt: 5'd0, busy: 1'b0, tx: 1'b1};
    vecs[2] = '{rst: 1'b0, en: 1'b0, data: 8'h00, ready: 1'b1, cnt: 5'd0, busy: 1'b0, tx: 1'b1};
    vecs[3] = '{rst: 1'b0, en: 1'b1, data: 8'hA5, ready: 1'b1, cnt: 5'd1, busy: 1'b1, tx: 1'b1};
    vecs[4] = '{rst: 1'b0, en: 1'b0, data: 8'h00, ready: 1'b1, cnt: 5'd0, busy: 1'b1, tx: 1'b0};

    // 1. reset and quiet line
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", {31'd0, tx_pin}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt", {27'd0, cnt}, 32'd0);
    low = 0;
    repeat (200) begin
      tick();
      if (tx_pin !== 1'b1) low++;
    end
    check("idle_low_cycles", low, 0);

    // 2. table: reset beats a write, then 0xA5 written and popped
    for (int i = 0; i < 5; i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      data = vecs[i].data;
      tick();
      check($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].ready});
      check($sformatf("vec%0d_cnt", i), {27'd0, cnt}, {27'd0, vecs[i].cnt});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("vec%0d_tx", i), {31'd0, tx_pin}, {31'd0, vecs[i].tx});
    end
    en = 1'b0;
    errs = 0;
    for (int t = 1; t <= 99; t++) begin
      tick();
      if (tx_pin !== exp_level(8'hA5, t)) begin
        if (errs == 0) $display("note: a5 waveform differs at offset %0d", t);
        errs++;
      end
      if (t == 99) check("a5_busy_last_stop", {31'd0, busy}, 32'd1);
    end
    check("a5_waveform_errors", errs, 0);
    tick();
    check("a5_busy_fall", {31'd0, busy}, 32'd0);
    check("a5_tx_idle", {31'd0, tx_pin}, 32'd1);
    check_frames("a5", 8'hA5, 1, 0);

    // 3. two back-to-back bytes
    repeat (20) tick();
    clear_rx();
    en = 1'b1;
    data = 8'h55;
    tick();
    data = 8'h0F;
    tick();
    en = 1'b0;
    wait_idle("pair_idle", 400);
    check("pair_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("pair_first", {24'd0, rx_q[0]}, 32'h55);
      check("pair_second", {24'd0, rx_q[1]}, 32'h0F);
      check("pair_pitch", rx_t[1] - rx_t[0], 100);
    end
    check("pair_framing", rx_bad, 0);

    // 4. overfill: 18 writes, the last one dropped
    clear_rx();
    r16 = 1'b0;
    r17 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 16) r16 = ready;
      if (k == 17) r17 = ready;
      en = 1'b1;
      data = 8'(k);
      tick();
    end
    en = 1'b0;
    check("fill_ready_16th_write", {31'd0, r16}, 32'd1);
    check("fill_ready_18th_write", {31'd0, r17}, 32'd0);
    check("fill_cnt_full", {27'd0, cnt}, 32'd16);
    check("fill_ready_full", {31'd0, ready}, 32'd0);
    wait_idle("fill_idle", 2100);
    check_frames("fill", 0, 17, 1);

    // 5. reset in the middle of data bit 3 of 0xFF with 3 bytes queued
    clear_rx();
    en = 1'b1;
    data = 8'hFF; tick();
    data = 8'h01; tick();
    data = 8'h02; tick();
    data = 8'h03; tick();
    en = 1'b0;
    check("midrst_cnt_before", {27'd0, cnt}, 32'd3);
    repeat (41) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", {31'd0, tx_pin}, 32'd1);
    check("midrst_cnt", {27'd0, cnt}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    tick();
    rst = 1'b0;
    low = 0;
    repeat (500) begin
      tick();
      if (tx_pin !== 1'b1) low++;
    end
    check("midrst_low_cycles", low, 0);
    check("midrst_frames", rx_q.size(), 0);

    // 6. all 256 byte values streamed through the line receiver
    clear_rx();
    begin
      int idx = 0;
      int guard = 0;
      while (idx < 256 && guard < 40000) begin
        if (ready) begin
          en = 1'b1;
          data = 8'(idx);
          idx++;
        end else begin
          en = 1'b0;
        end
        tick();
        guard++;
      end
      en = 1'b0;
      check("stream_all_written", idx, 256);
    end
    wait_idle("stream_idle", 2000);
    check_frames("stream", 0, 256, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter, 8 data bits, 1 stop bit, no parity (8N1), LSB first. Bytes are pushed through a valid/ready-style write port into an internal FIFO and serialised onto the TX pin. Bit timing matches the team's UART receiver, so a tx pin looped to the receiver's rx pin returns the same bytes. Sits between user logic and the board UART TX pin.

Parameters:
CLK_FRE, 50, system clock frequency in MHz.
UART_RATE, 115200, baud rate in bit/s.
FIFO_DEPTH, 16, FIFO entries. Must be a power of two and at least 2.
RATE_CNT (derived, localparam), CLK_FRE*1000_000/UART_RATE - 1. One bit period is RATE_CNT+1 cycles (434 cycles at the defaults). Must be at least 1.

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge.
i_sys_rst  in  1  synchronous reset, active-high.
i_send_en  in  1  write strobe; one byte per asserted cycle.
i_send_data  in  8  byte to send; sampled when i_send_en && o_send_ready.
o_send_ready  out  1  FIFO not full; a write is accepted only when high.
o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  number of bytes currently in the FIFO.
o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
o_tx_pin  out  1  serial output; idle high. Registered.

Behaviour:
- Reset, when i_sys_rst is high at an edge:
  - o_tx_pin=1, FIFO flushed, o_fifo_cnt=0, o_send_ready=1, o_busy=0.
  - State = TX_IDLE; bit counter and cycle counter = 0.
  - Reset overrides any write in the same cycle.
- FIFO:
  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - o_send_ready = (o_fifo_cnt < FIFO_DEPTH).
  - A write attempted while full is dropped silently; FIFO contents are unchanged.
  - Push and pop in the same cycle: count is unchanged. When full, a same-cycle pop does not make the push accepted, because ready is evaluated from the pre-edge count.
  - A pop never happens when the FIFO is empty.
- State machine (TX_IDLE, TX_START, TX_DATA, TX_STOP):
  - TX_IDLE: o_tx_pin=1. If FIFO non-empty: pop the head into the shift register, drive o_tx_pin<=0, clear the cycle counter, go to TX_START.
  - TX_START: hold 0 for RATE_CNT+1 cycles total. At the end of the period, drive data bit 0, set bit index to 0, go to TX_DATA.
  - TX_DATA: each bit is held RATE_CNT+1 cycles, LSB first. After bit 7's period, drive 1 and go to TX_STOP.
  - TX_STOP: hold 1 for RATE_CNT+1 cycles. On the last cycle of the stop period:
    - if the FIFO is non-empty, pop, drive 0, and go directly to TX_START (no idle gap);
    - otherwise go to TX_IDLE.
- Latency: a write accepted at edge N (FIFO empty, TX_IDLE) makes the count visible after N. The pop occurs at edge N+1, and o_tx_pin goes low after edge N+1. The start bit occupies cycles N+2 .. N+RATE_CNT+2.
- Back-to-back frames have a pitch of exactly 10*(RATE_CNT+1) cycles.
- A data byte is latched at pop time. Later FIFO writes do not affect the frame in flight.
- o_busy = (state != TX_IDLE) || (o_fifo_cnt != 0). It deasserts the cycle after the final stop-bit period ends with an empty FIFO.
- Reset mid-frame: the frame is truncated and o_tx_pin is high after the reset edge. Queued bytes are discarded; nothing is resent.

Test Plan:
(Sim parameters CLK_FRE=1, UART_RATE=100000 → RATE_CNT=9, 10 cycles/bit, FIFO_DEPTH=16.)
1. Reset: hold i_sys_rst for 3 cycles, release -> o_tx_pin=1, o_send_ready=1, o_busy=0, o_fifo_cnt=0; no pin activity for 200 cycles.
2. Single byte 0xA5 written at edge N -> o_tx_pin 0 for cycles N+2..N+11; then 1,0,1,0,0,1,0,1 at 10 cycles each; stop high 10 cycles; o_busy falls after cycle N+101.
3. Write 0x55 then 0x0F on consecutive cycles -> second start-bit falling edge exactly 100 cycles after the first; line is never high between the first stop bit and the second start bit beyond 10 cycles.
4. Fill: assert i_send_en for 18 consecutive cycles with data 0x00..0x11 -> bytes 0x00..0x10 accepted, o_send_ready low on the 18th cycle, 0x11 dropped; exactly 17 frames sent, in order.
5. Reset asserted during data bit 3 of 0xFF with 3 bytes queued -> o_tx_pin=1 after the reset edge, o_fifo_cnt=0, no low level for the following 500 cycles.
6. Loopback o_tx_pin to the team's uart_rx (same parameters), send 0x00..0xFF back-to-back -> 256 o_recv_en pulses, and o_recv_data matches each byte in order.
